// File: rtl/nes_pkg.sv
// Shared NES system constants and the OAM DMA state encoding.
// Imported by every block that decodes CPU addresses or talks to the DMA engine.
package nes_pkg;

    localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR  = 16'h2004;
    localparam logic [7:0]  DMA_LAST_IDX  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_t;

    function automatic logic is_dma_trigger(input logic ce, input logic wr, input logic [15:0] addr);
        return ce & wr & (addr == DMA_TRIG_ADDR);
    endfunction

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side strobe inputs and DMA bus outputs of the OAM DMA engine.
// master = the DMA engine, slave = the CPU/system-bus side that feeds it.
interface oam_dma_if;
    import nes_pkg::*;

    logic        cpu_ce;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  bus_rdata;
    logic        cpu_halt;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic        dma_wr;
    logic [7:0]  dma_wdata;
    logic        busy;

    modport master (
        input  cpu_ce, cpu_wr, cpu_addr, cpu_wdata, bus_rdata,
        output cpu_halt, dma_addr, dma_rd, dma_wr, dma_wdata, busy
    );

    modport slave (
        output cpu_ce, cpu_wr, cpu_addr, cpu_wdata, bus_rdata,
        input  cpu_halt, dma_addr, dma_rd, dma_wr, dma_wdata, busy
    );

endinterface

// File: rtl/oam_dma.sv
// OAM DMA: copies one 256-byte CPU page to OAMDATA, one byte per get/put CPU-cycle pair.
// Latency: 513 CPU cycles from HALT to IDLE, 514 when an ALIGN cycle is needed.
// Backpressure: none accepted; the CPU is held via cpu_halt while the engine owns the bus.
module oam_dma
    import nes_pkg::*;
(
    input  logic      m_clk,
    input  logic      rst,
    oam_dma_if.master port
);

    dma_state_t state_q, state_d;
    logic       parity_q, parity_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge m_clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
        end
    end

    // Every transition is gated by cpu_ce, so the engine advances exactly once per CPU cycle.
    always_comb begin
        state_d  = state_q;
        parity_d = parity_q ^ port.cpu_ce;
        page_d   = page_q;
        idx_d    = idx_q;
        data_d   = data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (is_dma_trigger(port.cpu_ce, port.cpu_wr, port.cpu_addr)) begin
                    page_d  = port.cpu_wdata;
                    idx_d   = 8'h00;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                // Reads must land on a get cycle; a put-phase HALT costs one extra cycle.
                if (port.cpu_ce) begin
                    state_d = parity_q ? ST_ALIGN : ST_READ;
                end
            end
            ST_ALIGN: begin
                if (port.cpu_ce) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (port.cpu_ce) begin
                    data_d  = port.bus_rdata;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (port.cpu_ce) begin
                    if (idx_q == DMA_LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_READ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        port.cpu_halt  = (state_q != ST_IDLE);
        port.busy      = (state_q != ST_IDLE);
        port.dma_addr  = 16'h0000;
        port.dma_rd    = 1'b0;
        port.dma_wr    = 1'b0;
        port.dma_wdata = 8'h00;

        case (state_q)
            ST_READ: begin
                port.dma_addr = {page_q, idx_q};
                port.dma_rd   = 1'b1;
            end
            ST_WRITE: begin
                port.dma_addr  = OAMDATA_ADDR;
                port.dma_wr    = 1'b1;
                port.dma_wdata = data_q;
            end
            default: begin
                port.dma_addr = 16'h0000;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: idle-write vector table, transfer table with a
// read/write scoreboard, plus hand sequences for reset-during-ce and mid-transfer abort.
module tb_oam_dma;
    import nes_pkg::*;

    logic m_clk = 1'b0;
    logic rst;
    oam_dma_if ifc();

    oam_dma dut (
        .m_clk (m_clk),
        .rst   (rst),
        .port  (ifc.master)
    );

    always #5 m_clk = ~m_clk;

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[15:8] ^ {a[6:0], a[7]} ^ 8'hA5;
    endfunction

    assign ifc.bus_rdata = mem(ifc.dma_addr);

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_rd_q[$];
    logic [7:0]  exp_wd_q[$];
    int          busy_cnt;
    int          wr_cnt;
    logic [15:0] last_rd;
    logic        par_m;
    logic        noise;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic        exp_busy;
    } vec_t;

    typedef struct {
        logic [7:0]  pg;
        logic        align;
        logic        noise;
        int          ign_at;
        int          exp_cyc;
        logic [15:0] last_rd;
    } xfer_t;

    vec_t  vt[6];
    xfer_t xt[5];

    function automatic logic [27:0] outs();
        return {ifc.cpu_halt, ifc.busy, ifc.dma_rd, ifc.dma_wr, ifc.dma_addr, ifc.dma_wdata};
    endfunction

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [27:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h, expected no such event", name, act);
    endtask

    // One CPU cycle: 11 non-enable m_clk edges, then the cpu_ce edge.
    task automatic cyc(input logic wr, input logic [15:0] addr, input logic [7:0] wd);
        logic [27:0] snap;
        ifc.cpu_ce    = 1'b0;
        ifc.cpu_wr    = noise;
        ifc.cpu_addr  = noise ? DMA_TRIG_ADDR : 16'h0000;
        ifc.cpu_wdata = noise ? 8'h09 : 8'h00;
        snap = outs();
        for (int i = 0; i < 11; i++) begin
            @(posedge m_clk);
            #1;
            check("stable_between_ce", outs(), snap);
        end
        ifc.cpu_ce    = 1'b1;
        ifc.cpu_wr    = wr;
        ifc.cpu_addr  = addr;
        ifc.cpu_wdata = wd;
        if (ifc.busy) busy_cnt++;
        if (ifc.dma_rd) begin
            check("rd_not_wr", 28'(ifc.dma_wr), 28'h0);
            if (exp_rd_q.size() == 0) fail_now("spurious_rd", 28'(ifc.dma_addr));
            else check("rd_addr", 28'(ifc.dma_addr), 28'(exp_rd_q.pop_front()));
            last_rd = ifc.dma_addr;
        end
        if (ifc.dma_wr) begin
            check("wr_addr", 28'(ifc.dma_addr), 28'(OAMDATA_ADDR));
            if (exp_wd_q.size() == 0) fail_now("spurious_wr", 28'(ifc.dma_wdata));
            else check("wr_data", 28'(ifc.dma_wdata), 28'(exp_wd_q.pop_front()));
            wr_cnt++;
        end
        if (!ifc.dma_rd && !ifc.dma_wr)
            check("quiet_bus_zero", {4'h0, ifc.dma_addr, ifc.dma_wdata}, 28'h0);
        @(posedge m_clk);
        #1;
        par_m = ~par_m;
        ifc.cpu_ce = 1'b0;
    endtask

    task automatic do_reset(input logic with_ce);
        ifc.cpu_ce    = with_ce;
        ifc.cpu_wr    = with_ce;
        ifc.cpu_addr  = DMA_TRIG_ADDR;
        ifc.cpu_wdata = 8'h55;
        rst = 1'b1;
        @(posedge m_clk);
        #1;
        rst = 1'b0;
        ifc.cpu_ce    = 1'b0;
        ifc.cpu_wr    = 1'b0;
        ifc.cpu_addr  = 16'h0000;
        ifc.cpu_wdata = 8'h00;
        par_m = 1'b0;
        exp_rd_q.delete();
        exp_wd_q.delete();
        busy_cnt = 0;
        wr_cnt   = 0;
    endtask

    // Triggers land on a CPU cycle whose parity makes HALT a put (align) or get cycle.
    task automatic start(input logic [7:0] pg, input logic align);
        if (par_m == align) cyc(1'b0, 16'h0000, 8'h00);
        for (int i = 0; i < 256; i++) begin
            exp_rd_q.push_back({pg, 8'(i)});
            exp_wd_q.push_back(mem({pg, 8'(i)}));
        end
        busy_cnt = 0;
        wr_cnt   = 0;
        cyc(1'b1, DMA_TRIG_ADDR, pg);
        check("busy_after_trigger", {26'h0, ifc.cpu_halt, ifc.busy}, 28'h3);
    endtask

    task automatic run_to_idle(input int ign_at);
        int n = 0;
        while (ifc.busy && n < 600) begin
            if (n == ign_at) cyc(1'b1, DMA_TRIG_ADDR, 8'h03);
            else cyc(1'b0, 16'h0000, 8'h00);
            n++;
        end
        if (ifc.busy) fail_now("transfer_timeout", 28'(n));
    endtask

    task automatic finish_xfer(input int exp_cyc, input logic [15:0] exp_last);
        check("busy_cycles", 28'(busy_cnt), 28'(exp_cyc));
        check("wr_count", 28'(wr_cnt), 28'd256);
        check("rd_queue_drained", 28'(exp_rd_q.size()), 28'd0);
        check("wr_queue_drained", 28'(exp_wd_q.size()), 28'd0);
        check("last_rd_addr", 28'(last_rd), 28'(exp_last));
        check("idle_outputs", outs(), 28'h0);
    endtask

    initial begin
        noise         = 1'b0;
        rst           = 1'b1;
        ifc.cpu_ce    = 1'b0;
        ifc.cpu_wr    = 1'b0;
        ifc.cpu_addr  = 16'h0000;
        ifc.cpu_wdata = 8'h00;
        last_rd       = 16'h0000;

        vt[0] = '{1'b1, 16'h4015, 8'h02, 1'b0};
        vt[1] = '{1'b1, 16'h4013, 8'h02, 1'b0};
        vt[2] = '{1'b0, 16'h4014, 8'h02, 1'b0};
        vt[3] = '{1'b1, 16'h2004, 8'h02, 1'b0};
        vt[4] = '{1'b1, 16'hC014, 8'h02, 1'b0};
        vt[5] = '{1'b1, 16'h0014, 8'h02, 1'b0};

        xt[0] = '{8'h02, 1'b0, 1'b0, -1,  513, 16'h02FF};
        xt[1] = '{8'h02, 1'b1, 1'b0, -1,  514, 16'h02FF};
        xt[2] = '{8'h02, 1'b0, 1'b0, 50,  513, 16'h02FF};
        xt[3] = '{8'hFF, 1'b0, 1'b1, -1,  513, 16'hFFFF};
        xt[4] = '{8'h00, 1'b1, 1'b0, 300, 514, 16'h00FF};

        repeat (3) @(posedge m_clk);
        do_reset(1'b0);
        check("reset_outputs", outs(), 28'h0);

        noise = 1'b1;
        foreach (vt[i]) begin
            cyc(vt[i].wr, vt[i].addr, vt[i].wd);
            check("idle_write_busy", 28'(ifc.busy), 28'(vt[i].exp_busy));
            check("idle_write_outputs", outs(), 28'h0);
        end
        noise = 1'b0;

        foreach (xt[i]) begin
            noise = xt[i].noise;
            start(xt[i].pg, xt[i].align);
            run_to_idle(xt[i].ign_at);
            noise = 1'b0;
            finish_xfer(xt[i].exp_cyc, xt[i].last_rd);
        end

        // Abort after 100 writes; reset is applied on a cpu_ce edge carrying a trigger.
        start(8'h02, 1'b0);
        begin
            int n = 0;
            while (wr_cnt < 100 && n < 600) begin
                cyc(1'b0, 16'h0000, 8'h00);
                n++;
            end
            check("writes_before_abort", 28'(wr_cnt), 28'd100);
        end
        do_reset(1'b1);
        check("abort_outputs", outs(), 28'h0);
        repeat (3) cyc(1'b0, 16'h0000, 8'h00);
        check("abort_stays_idle", outs(), 28'h0);
        check("abort_no_writes", 28'(wr_cnt), 28'd0);

        start(8'h07, 1'b0);
        run_to_idle(-1);
        finish_xfer(513, 16'h07FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 m_clk  input  1  master clock, 21.4773 MHz; all state on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high; sampled on the rising edge of m_clk.
REQ-003 cpu_ce  input  1  CPU-cycle enable pulse from clock_gen; high for 1 m_clk in every 12.
REQ-004 cpu_wr  input  1  CPU write strobe; qualified by cpu_ce.
REQ-005 cpu_addr  input  16  CPU address.
REQ-006 cpu_wdata  input  8  CPU write data.
REQ-007 bus_rdata  input  8  system bus read data, valid at a cpu_ce edge.
REQ-008 cpu_halt  output  1  holds the CPU (RDY low) while a transfer is active.
REQ-009 dma_addr  output  16  DMA bus address.
REQ-010 dma_rd  output  1  DMA read cycle.
REQ-011 dma_wr  output  1  DMA write cycle.
REQ-012 dma_wdata  output  8  DMA write data.
REQ-013 busy  output  1  transfer in progress.

Function
REQ-014 All state changes SHALL occur only on m_clk edges with cpu_ce=1, except reset.
REQ-015 A register, parity, SHALL toggle on every cpu_ce; 0 = get cycle, 1 = put cycle.
REQ-016 Trigger: cpu_ce & cpu_wr & cpu_addr==16'h4014 in IDLE SHALL latch page=cpu_wdata, clear idx, and move to HALT.
REQ-017 A trigger while not IDLE SHALL be ignored; the page SHALL be unchanged.
REQ-018 Writes to any other address SHALL have no effect.
REQ-019 States: IDLE, HALT, ALIGN, READ, WRITE.
REQ-020 HALT SHALL last one CPU cycle; on exit, go to ALIGN if parity==1 in that cycle, else to READ.
REQ-021 ALIGN SHALL last one CPU cycle, then go to READ.
REQ-022 READ SHALL drive dma_addr={page,idx} and dma_rd=1; at its cpu_ce, latch bus_rdata into the data register and go to WRITE.
REQ-023 WRITE SHALL drive dma_addr=16'h2004, dma_wr=1, dma_wdata=the data register; at its cpu_ce, go to IDLE if idx==8'hFF, else idx+1 and go to READ.
REQ-024 idx SHALL be 8 bits; the page SHALL never increment; the address SHALL never cross the page.
REQ-025 Transfer length SHALL be 513 CPU cycles (no ALIGN) or 514 (ALIGN), counted from the HALT state to the return to IDLE.
REQ-026 cpu_halt and busy SHALL be high in every state except IDLE; both are combinational from the state.
REQ-027 In IDLE, HALT and ALIGN: dma_rd=0, dma_wr=0, dma_addr=0, dma_wdata=0.
REQ-028 Exactly 256 dma_wr cycles SHALL occur per transfer, in idx order 00..FF.

Reset
REQ-029 rst SHALL force state=IDLE, parity=0, page=0, idx=0, data=0 on the same edge, regardless of cpu_ce.
REQ-030 All outputs SHALL be 0 after reset.
REQ-031 rst mid-transfer SHALL abort the transfer with no further dma_wr; cpu_halt SHALL be 0 from the next cycle.

Structure
REQ-032 The constants DMA_TRIG_ADDR=16'h4014, OAMDATA_ADDR=16'h2004 and the 3-bit state encoding SHALL live in the shared nes_pkg package.
REQ-033 The block SHALL be a single module with no sub-modules; the parity counter is inline.

Verification
REQ-034 After reset, write 8'h02 to 16'h4014 on an even cycle -> 513 CPU cycles busy; reads 0200..02FF; 256 writes to 2004 with matching data; then halt=0.
REQ-035 Same trigger landing on an odd cycle -> one ALIGN cycle inserted; 514 CPU cycles busy.
REQ-036 Trigger 8'h03 issued mid-transfer of page 02 -> ignored; all 256 reads remain 02xx.
REQ-037 Assert rst after 100 writes -> next cycle: halt=0, busy=0, dma_wr=0; a new trigger with 8'h07 runs a full, clean transfer.
REQ-038 Between cpu_ce pulses, toggle cpu_wr and cpu_addr=4014 -> no trigger; outputs stable for all 11 non-enable m_clk cycles.
REQ-039 Page 8'hFF -> final read address FFFF; no wrap into page 00; dma_wr count = 256.
